wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/dlx_pipe_pkg.sv | 35 +++
 rtl/load_align.sv | 41 ++++
 rtl/wb_stage.sv | 117 +++++++++++
 tb/tb_wb_stage.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dlx_pipe_pkg.sv
// rtl/dlx_pipe_pkg.sv - shared MEM/WB pipeline definitions
// Purpose: MEM/WB bundle field positions (bit 0 is the MSB of the bundle),
//          load-size codes and write-back state encoding. Imported by both
//          the MEM/WB register and the write-back stage.
// Ports:   none (package).
package dlx_pipe_pkg;

  localparam int BUNDLE_WIDTH   = 179;

  // Start bit of each field; each field runs toward higher bit numbers.
  localparam int NEXTPC_POS     = 0;    // 32 bits
  localparam int DESTREG_POS    = 32;   // 5 bits
  localparam int ALURESULT_POS  = 37;   // 32 bits
  localparam int DATAOUT_POS    = 69;   // 32 bits
  localparam int PCTOREG_POS    = 101;
  localparam int REGWRITE_POS   = 102;
  localparam int MEMTOREG_POS   = 103;
  localparam int LOADSIGN_POS   = 104;
  localparam int DSIZE_POS      = 105;  // 2 bits
  localparam int TRAP_POS       = 107;
  localparam int FDESTREG_POS   = 108;  // 5 bits
  localparam int FBUSW_POS      = 113;  // 64 bits
  localparam int FPREGWRITE_POS = 177;
  localparam int MUL_POS        = 178;

  // Load sizes; any code with the upper bit set is a word load.
  localparam logic [1:0] DSIZE_BYTE = 2'b00;
  localparam logic [1:0] DSIZE_HALF = 2'b01;

  // Write-back state machine encoding.
  localparam logic [1:0] STATE_RUN    = 2'd0;
  localparam logic [1:0] STATE_TRAP   = 2'd1;
  localparam logic [1:0] STATE_HALTED = 2'd2;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - big-endian load lane selection and extension
// Purpose: picks the byte/half/word addressed by a load out of the memory
//          word and sign- or zero-extends it to 32 bits. Combinational.
// Ports:   dataOut  [0:31] memory word, lane k at bits [8k:8k+7]
//          offset   [0:1]  address low bits
//          dSize    [0:1]  00 byte, 01 half, 1x word
//          loadSign        1 = sign-extend byte/half
//          loadWord [0:31] aligned, extended result
module load_align
  import dlx_pipe_pkg::*;
(
  input  logic [0:31] dataOut,
  input  logic [0:1]  offset,
  input  logic [0:1]  dSize,
  input  logic        loadSign,
  output logic [0:31] loadWord
);

  logic [0:7]  byteVal;
  logic [0:15] halfVal;

  always_comb begin
    byteVal = 8'h00;
    case (offset)
      2'd0:    byteVal = dataOut[0:7];
      2'd1:    byteVal = dataOut[8:15];
      2'd2:    byteVal = dataOut[16:23];
      default: byteVal = dataOut[24:31];
    endcase
    // Half loads ignore offset[1]; offset[0] picks the upper or lower half.
    halfVal = offset[0] ? dataOut[16:31] : dataOut[0:15];

    loadWord = dataOut;
    if (dSize == DSIZE_BYTE) begin
      loadWord = {{24{loadSign & byteVal[0]}}, byteVal};
    end else if (dSize == DSIZE_HALF) begin
      loadWord = {{16{loadSign & halfVal[0]}}, halfVal};
    end
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - DLX write-back stage
// Purpose: accepts one MEM/WB bundle per unstalled cycle, issues integer and
//          FP register-file writes one clock later, counts retired and
//          multiply instructions, and halts after a trap.
// Ports:   clk, reset (sync, active-high), in [0:WIDTH-1] MEM/WB bundle,
//          stall; rf_we/rf_waddr/rf_wdata integer write port;
//          fp_we/fp_waddr/fp_wdata FP write port; halt; retired [0:31];
//          mul_retired [0:15] (saturating).
module wb_stage
  import dlx_pipe_pkg::*;
#(
  parameter int WIDTH = BUNDLE_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [0:WIDTH-1] in,
  input  logic             stall,
  output logic             rf_we,
  output logic [0:4]       rf_waddr,
  output logic [0:31]      rf_wdata,
  output logic             fp_we,
  output logic [0:4]       fp_waddr,
  output logic [0:63]      fp_wdata,
  output logic             halt,
  output logic [0:31]      retired,
  output logic [0:15]      mul_retired
);

  logic [0:31] nextPc;
  logic [0:4]  destReg;
  logic [0:31] aluResult;
  logic [0:31] dataOut;
  logic        pcToReg, regWrite, memToReg, loadSign, trap, fpRegWrite, mul;
  logic [0:1]  dSize;
  logic [0:4]  fDestReg;
  logic [0:63] fbusW;

  assign nextPc     = in[NEXTPC_POS +: 32];
  assign destReg    = in[DESTREG_POS +: 5];
  assign aluResult  = in[ALURESULT_POS +: 32];
  assign dataOut    = in[DATAOUT_POS +: 32];
  assign pcToReg    = in[PCTOREG_POS];
  assign regWrite   = in[REGWRITE_POS];
  assign memToReg   = in[MEMTOREG_POS];
  assign loadSign   = in[LOADSIGN_POS];
  assign dSize      = in[DSIZE_POS +: 2];
  assign trap       = in[TRAP_POS];
  assign fDestReg   = in[FDESTREG_POS +: 5];
  assign fbusW      = in[FBUSW_POS +: 64];
  assign fpRegWrite = in[FPREGWRITE_POS];
  assign mul        = in[MUL_POS];

  logic [0:31] loadWord;
  logic [0:31] intResult;
  logic [1:0]  state;
  logic        accept;
  logic        intWrite;
  logic        fpWrite;

  load_align u_load_align (
    .dataOut  (dataOut),
    .offset   (aluResult[30:31]),
    .dSize    (dSize),
    .loadSign (loadSign),
    .loadWord (loadWord)
  );

  assign intResult = pcToReg  ? nextPc :
                     memToReg ? loadWord : aluResult;

  // Only RUN accepts; bundles seen in TRAP or HALTED are dropped.
  assign accept   = !stall && (state == STATE_RUN);
  assign intWrite = accept && regWrite && (destReg != 5'd0);
  assign fpWrite  = accept && fpRegWrite;
  assign halt     = (state == STATE_HALTED);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= STATE_RUN;
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      fp_we       <= 1'b0;
      fp_waddr    <= '0;
      fp_wdata    <= '0;
      retired     <= '0;
      mul_retired <= '0;
    end else begin
      case (state)
        STATE_RUN:    if (accept && trap) state <= STATE_TRAP;
        STATE_TRAP:   state <= STATE_HALTED;
        STATE_HALTED: state <= STATE_HALTED;
        default:      state <= STATE_RUN;
      endcase

      rf_we <= intWrite;
      fp_we <= fpWrite;
      // Address/data hold their last written values when no write issues.
      if (intWrite) begin
        rf_waddr <= destReg;
        rf_wdata <= intResult;
      end
      if (fpWrite) begin
        fp_waddr <= fDestReg;
        fp_wdata <= fbusW;
      end

      if (accept && (regWrite || fpRegWrite || trap)) begin
        retired <= retired + 32'd1;
      end
      if (accept && mul && (mul_retired != 16'hFFFF)) begin
        mul_retired <= mul_retired + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage
module tb_wb_stage;

  typedef struct {
    logic [31:0] nextPc;
    logic [4:0]  destReg;
    logic [31:0] aluResult;
    logic [31:0] dataOut;
    logic        pcToReg;
    logic        regWrite;
    logic        memToReg;
    logic        loadSign;
    logic [1:0]  dSize;
    logic        trap;
    logic [4:0]  fDestReg;
    logic [63:0] fbusW;
    logic        fpRegWrite;
    logic        mul;
  } bundle_t;

  typedef struct {
    bundle_t     b;
    logic        st;
    logic        expRfWe;
    logic [4:0]  expRfWaddr;
    logic [31:0] expRfWdata;
    logic        expFpWe;
    logic [63:0] expFpWdata;
    logic [31:0] expRetInc;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [0:178] inBus;
  logic         stall;
  logic         rf_we;
  logic [0:4]   rf_waddr;
  logic [0:31]  rf_wdata;
  logic         fp_we;
  logic [0:4]   fp_waddr;
  logic [0:63]  fp_wdata;
  logic         halt;
  logic [0:31]  retired;
  logic [0:15]  mul_retired;

  wb_stage #(.WIDTH(179)) dut (
    .clk         (clk),
    .reset       (reset),
    .in          (inBus),
    .stall       (stall),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .fp_we       (fp_we),
    .fp_waddr    (fp_waddr),
    .fp_wdata    (fp_wdata),
    .halt        (halt),
    .retired     (retired),
    .mul_retired (mul_retired)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic        mRfWe, mFpWe;
  logic [4:0]  mRfWaddr, mFpWaddr;
  logic [31:0] mRfWdata;
  logic [63:0] mFpWdata;
  logic [31:0] mRetired;
  logic [15:0] mMul;
  int          mSinceTrap;   // -1 = running, else cycles since trap acceptance

  function automatic bundle_t mkB(logic [31:0] npc, logic [4:0] dst, logic [31:0] alu,
                                  logic [31:0] dout, logic p2r, logic rw, logic m2r,
                                  logic ls, logic [1:0] ds, logic tr, logic [4:0] fd,
                                  logic [63:0] fb, logic fw, logic ml);
    bundle_t b;
    b.nextPc = npc; b.destReg = dst; b.aluResult = alu; b.dataOut = dout;
    b.pcToReg = p2r; b.regWrite = rw; b.memToReg = m2r; b.loadSign = ls;
    b.dSize = ds; b.trap = tr; b.fDestReg = fd; b.fbusW = fb;
    b.fpRegWrite = fw; b.mul = ml;
    return b;
  endfunction

  function automatic logic [0:178] pack(bundle_t b);
    logic [0:178] v;
    v[0:31]    = b.nextPc;
    v[32:36]   = b.destReg;
    v[37:68]   = b.aluResult;
    v[69:100]  = b.dataOut;
    v[101]     = b.pcToReg;
    v[102]     = b.regWrite;
    v[103]     = b.memToReg;
    v[104]     = b.loadSign;
    v[105:106] = b.dSize;
    v[107]     = b.trap;
    v[108:112] = b.fDestReg;
    v[113:176] = b.fbusW;
    v[177]     = b.fpRegWrite;
    v[178]     = b.mul;
    return v;
  endfunction

  // Load value from arithmetic on the big-endian word: lane k sits 8*(3-k) bits up.
  function automatic logic [31:0] loadModel(bundle_t b);
    logic [31:0] off, v;
    off = {30'd0, b.aluResult[1:0]};
    if (b.dSize[1]) return b.dataOut;
    if (b.dSize == 2'b01) begin
      v = (b.dataOut >> (16 * (1 - off / 2))) & 32'h0000FFFF;
      if (b.loadSign && v[15]) v = v | 32'hFFFF0000;
    end else begin
      v = (b.dataOut >> (8 * (3 - off))) & 32'h000000FF;
      if (b.loadSign && v[7]) v = v | 32'hFFFFFF00;
    end
    return v;
  endfunction

  task automatic modelStep(bundle_t b, logic st, logic rst);
    logic acc;
    if (rst) begin
      mRfWe = 0; mFpWe = 0; mRfWaddr = 0; mFpWaddr = 0; mRfWdata = 0; mFpWdata = 0;
      mRetired = 0; mMul = 0; mSinceTrap = -1;
      return;
    end
    acc = !st && (mSinceTrap < 0);
    if (mSinceTrap >= 0) mSinceTrap++;
    else if (acc && b.trap) mSinceTrap = 0;
    mRfWe = acc && b.regWrite && (b.destReg != 0);
    if (mRfWe) begin
      mRfWaddr = b.destReg;
      mRfWdata = b.pcToReg ? b.nextPc : (b.memToReg ? loadModel(b) : b.aluResult);
    end
    mFpWe = acc && b.fpRegWrite;
    if (mFpWe) begin
      mFpWaddr = b.fDestReg;
      mFpWdata = b.fbusW;
    end
    if (acc && (b.regWrite || b.fpRegWrite || b.trap)) mRetired = mRetired + 1;
    if (acc && b.mul && mMul < 16'hFFFF) mMul = mMul + 1;
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkAll(string tag);
    chk({tag, " rf_we"}, 64'(rf_we), 64'(mRfWe));
    chk({tag, " rf_waddr"}, 64'(rf_waddr), 64'(mRfWaddr));
    chk({tag, " rf_wdata"}, 64'(rf_wdata), 64'(mRfWdata));
    chk({tag, " fp_we"}, 64'(fp_we), 64'(mFpWe));
    chk({tag, " fp_waddr"}, 64'(fp_waddr), 64'(mFpWaddr));
    chk({tag, " fp_wdata"}, fp_wdata, mFpWdata);
    chk({tag, " halt"}, 64'(halt), 64'(mSinceTrap >= 1));
    chk({tag, " retired"}, 64'(retired), 64'(mRetired));
    chk({tag, " mul_retired"}, 64'(mul_retired), 64'(mMul));
  endtask

  task automatic step(bundle_t b, logic st, logic rst, bit doCheck, string tag);
    inBus = pack(b);
    stall = st;
    reset = rst;
    @(posedge clk);
    #1;
    modelStep(b, st, rst);
    if (doCheck) checkAll(tag);
  endtask

  vec_t        vecs[9];
  bundle_t     nop, b;
  logic [31:0] retBefore;
  logic        st, rst;

  initial begin
    nop = mkB(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 64'd0, 0, 0);
    inBus = '0; stall = 0; reset = 1;
    mSinceTrap = -1;

    // Reset with a live write bundle present: it must be discarded.
    step(mkB(32'h4, 5'd9, 32'h55, 0, 0, 1, 0, 0, 2'b10, 1, 5'd1, 64'd7, 1, 1), 0, 1, 1, "reset");
    step(nop, 0, 1, 1, "reset2");

    //            nextPc        dst    alu            dout          p2r rw m2r ls dsz   tr fd     fbus                       fw ml
    vecs[0] = '{mkB(0,            5'd5,  32'h0000_1000, 32'h8012_3456, 0, 1, 1, 1, 2'b00, 0, 5'd0, 64'd0,                     0, 0), 0, 1, 5'd5,  32'hFFFF_FF80, 0, 64'd0, 1};
    vecs[1] = '{mkB(0,            5'd3,  32'h0000_2002, 32'h1234_ABCD, 0, 1, 1, 0, 2'b01, 0, 5'd0, 64'd0,                     0, 0), 0, 1, 5'd3,  32'h0000_ABCD, 0, 64'd0, 1};
    vecs[2] = '{mkB(32'h0000_0108, 5'd31, 32'h0000_0000, 32'h0,         1, 1, 0, 0, 2'b10, 0, 5'd0, 64'h3FF0_0000_0000_0000, 1, 0), 0, 1, 5'd31, 32'h0000_0108, 1, 64'h3FF0_0000_0000_0000, 1};
    vecs[3] = '{mkB(0,            5'd0,  32'h0000_0077, 32'h0,         0, 1, 0, 0, 2'b10, 0, 5'd0, 64'd0,                     0, 0), 0, 0, 5'd0,  32'h0,         0, 64'd0, 1};
    vecs[4] = '{mkB(0,            5'd8,  32'h0000_0003, 32'h1234_56F7, 0, 1, 1, 0, 2'b00, 0, 5'd0, 64'd0,                     0, 0), 0, 1, 5'd8,  32'h0000_00F7, 0, 64'd0, 1};
    vecs[5] = '{mkB(0,            5'd9,  32'h0000_0000, 32'h8001_7FFF, 0, 1, 1, 1, 2'b01, 0, 5'd0, 64'd0,                     0, 0), 0, 1, 5'd9,  32'hFFFF_8001, 0, 64'd0, 1};
    vecs[6] = '{mkB(0,            5'd10, 32'h0000_0001, 32'h0,         0, 1, 0, 0, 2'b10, 1, 5'd4, 64'd5,                     1, 0), 1, 0, 5'd0,  32'h0,         0, 64'd0, 0};
    vecs[7] = '{mkB(0,            5'd11, 32'h0000_0002, 32'hDEAD_BEEF, 0, 1, 1, 1, 2'b11, 0, 5'd0, 64'd0,                     0, 0), 0, 1, 5'd11, 32'hDEAD_BEEF, 0, 64'd0, 1};
    vecs[8] = '{mkB(0,            5'd12, 32'h0000_1234, 32'hFFFF_FFFF, 0, 1, 0, 1, 2'b00, 0, 5'd2, 64'hCAFE,                1, 0), 0, 1, 5'd12, 32'h0000_1234, 1, 64'hCAFE,  1};

    for (int i = 0; i < 9; i++) begin
      retBefore = retired;
      step(vecs[i].b, vecs[i].st, 0, 1, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d tbl rf_we", i), 64'(rf_we), 64'(vecs[i].expRfWe));
      if (vecs[i].expRfWe) begin
        chk($sformatf("vec%0d tbl rf_waddr", i), 64'(rf_waddr), 64'(vecs[i].expRfWaddr));
        chk($sformatf("vec%0d tbl rf_wdata", i), 64'(rf_wdata), 64'(vecs[i].expRfWdata));
      end
      chk($sformatf("vec%0d tbl fp_we", i), 64'(fp_we), 64'(vecs[i].expFpWe));
      if (vecs[i].expFpWe) chk($sformatf("vec%0d tbl fp_wdata", i), fp_wdata, vecs[i].expFpWdata);
      chk($sformatf("vec%0d tbl retired", i), 64'(retired), 64'(retBefore + vecs[i].expRetInc));
    end

    // Trap sequence: own write happens, then halt and everything is dropped.
    step(nop, 0, 1, 1, "trapRst");
    step(mkB(0, 5'd7, 32'h99, 0, 0, 1, 0, 0, 2'b10, 1, 0, 64'd0, 0, 0), 0, 0, 1, "trap");
    chk("trap r7 we", 64'(rf_we), 64'd1);
    chk("trap r7 addr", 64'(rf_waddr), 64'd7);
    chk("trap halt early", 64'(halt), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step(mkB(0, 5'd6, 32'h1, 0, 0, 1, 0, 0, 2'b10, 0, 5'd3, 64'd1, 1, 1), 0, 0, 1, "posttrap");
      chk("posttrap rf_we", 64'(rf_we), 64'd0);
      chk("posttrap fp_we", 64'(fp_we), 64'd0);
      chk("posttrap halt", 64'(halt), 64'd1);
      chk("posttrap retired", 64'(retired), 64'd1);
    end
    step(nop, 0, 1, 1, "haltRst");
    chk("haltRst halt", 64'(halt), 64'd0);
    chk("haltRst retired", 64'(retired), 64'd0);

    // Stall together with trap: not accepted, no state change.
    step(mkB(0, 5'd4, 32'h1, 0, 0, 1, 0, 0, 2'b10, 1, 0, 64'd0, 0, 0), 1, 0, 1, "stallTrap");
    step(nop, 0, 0, 1, "stallTrap2");
    chk("stallTrap halt", 64'(halt), 64'd0);

    // Randomized run against the model.
    for (int i = 0; i < 600; i++) begin
      b = mkB($urandom, 5'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 2'($urandom), $urandom_range(0, 24) == 0,
              5'($urandom), {$urandom, $urandom}, 1'($urandom), 1'($urandom));
      st  = ($urandom_range(0, 3) == 0);
      rst = (mSinceTrap >= 4) || ($urandom_range(0, 79) == 0);
      step(b, st, rst, 1, "rand");
    end

    // Multiply saturation: preload to FFFE, then three more with stall toggling.
    step(nop, 0, 1, 1, "mulRst");
    for (int i = 0; i < 65534; i++) begin
      step(mkB(0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 64'd0, 0, 1), 0, 0, 0, "preload");
    end
    chk("mul preload", 64'(mul_retired), 64'hFFFE);
    for (int i = 0; i < 5; i++) begin
      step(mkB(0, 5'd2, 32'h2, 0, 0, 1, 0, 0, 2'b10, 0, 5'd1, 64'd2, 1, 1), 1'(i % 2), 0, 1, "mulSat");
      chk("mulSat value", 64'(mul_retired), 64'hFFFF);
      if (i % 2 == 1) begin
        chk("mulSat stalled rf_we", 64'(rf_we), 64'd0);
        chk("mulSat stalled fp_we", 64'(fp_we), 64'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
